vx_barrier_unit: RTL and testbench

Warp barrier tracker that consumes `gpu_barrier_t` requests produced by the GPU-ops execute path and sits directly upstream of the warp scheduler. It counts warp arrivals per barrier ID and holds arriving warps stalled. When the last expected warp arrives, it releases them with a one-cycle release pulse. It also latches the expected barrier size and flags inconsistent sizes.

---
 rtl/vx_barrier_unit_pkg.sv | 29 ++
 rtl/vx_barrier_unit_if.sv | 25 ++
 rtl/vx_barrier_unit_entry.sv | 60 ++++++
 rtl/vx_barrier_unit.sv | 76 +++++++
 tb/tb_vx_barrier_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/vx_barrier_unit_pkg.sv
// Shared GPU types for the barrier unit: request and per-barrier state layouts.
// Widths here size the request bus, the interface and every barrier entry.
package vx_barrier_unit_pkg;

   localparam int NUM_WARPS    = 4;
   localparam int NUM_BARRIERS = 4;
   localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
   // One spare id bit so the execute path can name a barrier that does not exist.
   localparam int BID_BITS     = NB_BITS + 1;

   typedef struct packed {
      logic                valid;
      logic [BID_BITS-1:0] id;
      logic [NW_BITS-1:0]  size_m1;
   } gpu_barrier_t;

   localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);

   typedef struct packed {
      logic                 busy;
      logic [NUM_WARPS-1:0] wmask;
      logic [NW_BITS-1:0]   count;
      logic [NW_BITS-1:0]   size_m1;
   } barrier_state_t;

endpackage

`define GPU_BARRIER_STATE_BITS $bits(vx_barrier_unit_pkg::barrier_state_t)

// File: rtl/vx_barrier_unit_if.sv
// Request/response bundle between the GPU-ops execute path and the barrier unit.
interface vx_barrier_unit_if;
   import vx_barrier_unit_pkg::*;

   logic                 req_valid;
   logic [NW_BITS-1:0]   req_wid;
   gpu_barrier_t         req_barrier;
   logic                 req_ready;
   logic [NUM_WARPS-1:0] stall_mask;
   logic                 release_valid;
   logic [NUM_WARPS-1:0] release_wmask;
   logic [NB_BITS-1:0]   release_id;
   logic                 size_err;

   modport master (
      output req_valid, req_wid, req_barrier,
      input  req_ready, stall_mask, release_valid, release_wmask, release_id, size_err
   );

   modport slave (
      input  req_valid, req_wid, req_barrier,
      output req_ready, stall_mask, release_valid, release_wmask, release_id, size_err
   );

endinterface

// File: rtl/vx_barrier_unit_entry.sv
// One barrier: arrival mask, arrival count and latched size, plus completion detect.
// Exposes its next-state mask so the top can register the stall mask without extra lag.
module VX_barrier_entry
   import vx_barrier_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sel_i,
   input  logic [NW_BITS-1:0]   wid_i,
   input  logic [NW_BITS-1:0]   size_m1_i,
   output logic [NUM_WARPS-1:0] wmask_nxt_o,
   output logic                 done_o,
   output logic [NUM_WARPS-1:0] done_wmask_o,
   output logic                 size_err_o
);

   barrier_state_t       state_q, state_d;
   logic [NUM_WARPS-1:0] wbit;
   logic [NW_BITS-1:0]   sz;
   logic                 dup;

   assign wbit = {{(NUM_WARPS-1){1'b0}}, 1'b1} << wid_i;
   assign dup  = |(state_q.wmask & wbit);
   assign sz   = state_q.busy ? state_q.size_m1 : size_m1_i;

   always_comb begin
      state_d      = state_q;
      done_o       = 1'b0;
      done_wmask_o = '0;
      size_err_o   = 1'b0;
      if (sel_i && !dup) begin
         size_err_o = state_q.busy && (size_m1_i != state_q.size_m1);
         if (state_q.count == sz) begin
            done_o        = 1'b1;
            done_wmask_o  = state_q.wmask | wbit;
            state_d.wmask = '0;
            state_d.count = '0;
            state_d.busy  = 1'b0;
         end else begin
            state_d.wmask   = state_q.wmask | wbit;
            state_d.count   = state_q.count + NW_BITS'(1);
            state_d.busy    = 1'b1;
            state_d.size_m1 = sz;
         end
      end
   end

   assign wmask_nxt_o = state_d.wmask;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= '0;
      else          state_q <= state_d;
   end

   // A stalled warp cannot issue, so a repeat arrival means an upstream bug.
   always_ff @(posedge clk) begin
      if (reset_n && sel_i) assert (!dup) else $warning("duplicate barrier arrival");
   end

endmodule

// File: rtl/vx_barrier_unit.sv
// Warp barrier tracker: decodes the barrier id, fans out to per-barrier entries,
// and registers the stall mask, release pulse and sticky size-error flag.
module vx_barrier_unit
   import vx_barrier_unit_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   vx_barrier_unit_if.slave bus
);

   logic                                   accept, in_range;
   logic [NUM_BARRIERS-1:0]                sel, done, serr;
   logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] wmask_nxt, done_wmask;
   logic [NUM_WARPS-1:0]                   stall_d, stall_q, rel_wmask_d, rel_wmask_q;
   logic [NB_BITS-1:0]                     rel_id_d, rel_id_q;
   logic                                   rel_valid_q, size_err_q;

   assign accept   = bus.req_valid && bus.req_barrier.valid;
   assign in_range = bus.req_barrier.id < BID_BITS'(NUM_BARRIERS);

   for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_entry
      assign sel[b] = accept && in_range && (bus.req_barrier.id == BID_BITS'(b));

      VX_barrier_entry u_entry (
         .clk          (clk),
         .reset_n      (reset_n),
         .sel_i        (sel[b]),
         .wid_i        (bus.req_wid),
         .size_m1_i    (bus.req_barrier.size_m1),
         .wmask_nxt_o  (wmask_nxt[b]),
         .done_o       (done[b]),
         .done_wmask_o (done_wmask[b]),
         .size_err_o   (serr[b])
      );
   end

   // At most one entry is selected per cycle, so OR-merging the release data is safe.
   always_comb begin
      stall_d     = '0;
      rel_wmask_d = '0;
      rel_id_d    = '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         stall_d     = stall_d | wmask_nxt[b];
         rel_wmask_d = rel_wmask_d | done_wmask[b];
         if (done[b]) rel_id_d = NB_BITS'(b);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_q     <= '0;
         rel_valid_q <= 1'b0;
         rel_wmask_q <= '0;
         rel_id_q    <= '0;
         size_err_q  <= 1'b0;
      end else begin
         stall_q     <= stall_d;
         rel_valid_q <= |done;
         rel_wmask_q <= rel_wmask_d;
         rel_id_q    <= rel_id_d;
         size_err_q  <= size_err_q | (|serr);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && accept) assert (in_range) else $warning("barrier id out of range");
   end

   assign bus.req_ready     = 1'b1;
   assign bus.stall_mask    = stall_q;
   assign bus.release_valid = rel_valid_q;
   assign bus.release_wmask = rel_wmask_q;
   assign bus.release_id    = rel_id_q;
   assign bus.size_err      = size_err_q;

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Scoreboard bench for vx_barrier_unit: expected releases queued at drive time,
// popped by a monitor when the release pulse appears; stall/size_err checked inline.
module tb_vx_barrier_unit;
   import vx_barrier_unit_pkg::*;

   typedef struct {
      logic [NUM_WARPS-1:0] wmask;
      logic [NB_BITS-1:0]   id;
   } rel_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic mon_en = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   rel_t exp_q[$];

   vx_barrier_unit_if bus();

   vx_barrier_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_rel(input int m, input int id);
      rel_t e;
      e.wmask = NUM_WARPS'(m);
      e.id    = NB_BITS'(id);
      exp_q.push_back(e);
   endtask

   // Called at a negedge; presents the request for exactly one rising edge.
   task automatic send(input int w, input int b, input int s, input logic bv = 1'b1);
      bus.req_valid           = 1'b1;
      bus.req_wid             = NW_BITS'(w);
      bus.req_barrier.valid   = bv;
      bus.req_barrier.id      = BID_BITS'(b);
      bus.req_barrier.size_m1 = NW_BITS'(s);
      @(negedge clk);
      bus.req_valid         = 1'b0;
      bus.req_barrier.valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.release_valid) begin
            if (exp_q.size() == 0) chk("spurious_release", 32'(bus.release_wmask), 32'h0);
            else begin
               rel_t e;
               e = exp_q.pop_front();
               chk("rel_wmask", 32'(bus.release_wmask), 32'(e.wmask));
               chk("rel_id", 32'(bus.release_id), 32'(e.id));
            end
         end else begin
            chk("idle_wmask", 32'(bus.release_wmask), 32'h0);
         end
      end
   end

   initial begin
      bus.req_valid   = 1'b0;
      bus.req_wid     = '0;
      bus.req_barrier = '0;
      idle(3);
      chk("rst_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_stall", 32'(bus.stall_mask), 32'h0);
      chk("rst_rel_v", 32'(bus.release_valid), 32'h0);
      chk("rst_rel_m", 32'(bus.release_wmask), 32'h0);
      chk("rst_rel_id", 32'(bus.release_id), 32'h0);
      chk("rst_serr", 32'(bus.size_err), 32'h0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      idle(1);

      // four-warp barrier, last arrival after a gap
      send(0, 1, 3); chk("b1_stall0", 32'(bus.stall_mask), 32'h1);
      send(1, 1, 3); chk("b1_stall1", 32'(bus.stall_mask), 32'h3);
      send(2, 1, 3); chk("b1_stall2", 32'(bus.stall_mask), 32'h7);
      idle(2);       chk("b1_hold", 32'(bus.stall_mask), 32'h7);
      expect_rel(4'b1111, 1);
      send(3, 1, 3); chk("b1_done", 32'(bus.stall_mask), 32'h0);
      idle(1);       chk("b1_pulse_end", 32'(bus.release_valid), 32'h0);

      // single-warp barrier completes at once
      expect_rel(4'b0100, 0);
      send(2, 0, 0); chk("single_stall", 32'(bus.stall_mask), 32'h0);
      chk("single_v", 32'(bus.release_valid), 32'h1);

      // interleaved barriers 0 and 2
      send(0, 0, 1); chk("il_s0", 32'(bus.stall_mask), 32'h1);
      send(1, 2, 1); chk("il_s1", 32'(bus.stall_mask), 32'h3);
      expect_rel(4'b1001, 0);
      send(3, 0, 1); chk("il_s2", 32'(bus.stall_mask), 32'h2);
      expect_rel(4'b0110, 2);
      send(2, 2, 1); chk("il_s3", 32'(bus.stall_mask), 32'h0);

      // size mismatch keeps latched size
      send(0, 3, 2); chk("sz_s0", 32'(bus.stall_mask), 32'h1);
      chk("sz_err0", 32'(bus.size_err), 32'h0);
      send(1, 3, 1); chk("sz_s1", 32'(bus.stall_mask), 32'h3);
      chk("sz_err1", 32'(bus.size_err), 32'h1);
      idle(2);       chk("sz_wait", 32'(bus.stall_mask), 32'h3);
      expect_rel(4'b0111, 3);
      send(2, 3, 2); chk("sz_done", 32'(bus.stall_mask), 32'h0);
      chk("sz_sticky", 32'(bus.size_err), 32'h1);

      // duplicate arrival is ignored
      send(1, 0, 1); chk("dup_s0", 32'(bus.stall_mask), 32'h2);
      send(1, 0, 1); chk("dup_s1", 32'(bus.stall_mask), 32'h2);
      chk("dup_norel", 32'(bus.release_valid), 32'h0);
      expect_rel(4'b0110, 0);
      send(2, 0, 1); chk("dup_done", 32'(bus.stall_mask), 32'h0);

      // dropped requests: out-of-range id, and barrier.valid low
      send(0, 5, 1); chk("oor_stall", 32'(bus.stall_mask), 32'h0);
      send(0, 1, 1, 1'b0); chk("inv_stall", 32'(bus.stall_mask), 32'h0);
      send(1, 1, 1); chk("inv_after", 32'(bus.stall_mask), 32'h2);
      expect_rel(4'b1010, 1);
      send(3, 1, 1); chk("inv_done", 32'(bus.stall_mask), 32'h0);

      // back-to-back completions
      expect_rel(4'b0001, 0);
      expect_rel(4'b0010, 1);
      send(0, 0, 0);
      send(1, 1, 0);
      idle(1);

      // release then a fresh episode re-latches size
      expect_rel(4'b0011, 2);
      send(0, 2, 1);
      send(1, 2, 1);
      send(2, 2, 2); chk("fresh_s0", 32'(bus.stall_mask), 32'h4);
      send(3, 2, 2); chk("fresh_s1", 32'(bus.stall_mask), 32'hc);
      expect_rel(4'b1101, 2);
      send(0, 2, 2); chk("fresh_done", 32'(bus.stall_mask), 32'h0);

      // reset mid-episode
      send(0, 2, 3);
      send(1, 2, 3); chk("mr_stall", 32'(bus.stall_mask), 32'h3);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      chk("mr_stall0", 32'(bus.stall_mask), 32'h0);
      chk("mr_nopulse", 32'(bus.release_valid), 32'h0);
      chk("mr_serr", 32'(bus.size_err), 32'h0);
      send(3, 2, 1); chk("mr_fresh", 32'(bus.stall_mask), 32'h8);
      chk("mr_norel", 32'(bus.release_valid), 32'h0);
      idle(2);

      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
